// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and its issue controller:
// 4-bit MD op codes, FSM state type and the start-op classifier.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Ops that occupy the arithmetic unit and must be issued to it.
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/mdu_watchdog.sv
// Issue-to-done watchdog: counts RUN cycles and flags an abort when the
// arithmetic unit fails to complete within TIMEOUT_CYC cycles; err is sticky.
module mdu_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic clear,
  output logic expire,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Expiry on the edge closing the TIMEOUT_CYC-th RUN cycle; done/flush win.
  assign expire = run && !clear && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (start) begin
        count <= '0;
      end else if (run) begin
        count <= count + 1'b1;
      end
      if (expire) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the multiply/divide unit: issues ops, stalls decode,
// owns HI/LO. Optional watchdog enabled by MDU_ISSUE_CTRL_TIMEOUT_EN.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  E_sel_MDU,
  input  logic [3:0]  D_sel_MDU,
  input  logic [31:0] E_rs,
  input  logic        mdu_busy,
  input  logic        mdu_done,
  input  logic [63:0] mdu_result,
  output logic        mdu_start,
  output logic        stall,
  output logic [31:0] E_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);

  mdu_state_t state, state_next;
  logic       mul_op;
  logic       timeout;
  logic       in_run;

  assign in_run = (state == ST_RUN);

`ifdef MDU_ISSUE_CTRL_TIMEOUT_EN
  mdu_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .start (mdu_start),
    .run   (in_run),
    .clear (req | mdu_done),
    .expire(timeout),
    .err   (err)
  );
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mdu_start) state_next = ST_RUN;
      ST_RUN:  if (req || mdu_done || timeout) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are held low while reset is asserted, independent of inputs.
  always_comb begin
    mdu_start = !reset && (state == ST_IDLE) && is_start_op(E_sel_MDU) && !req;
    stall     = !reset && (D_sel_MDU != OP_NONE) && (in_run || mdu_start || mdu_busy);
    case (E_sel_MDU)
      OP_MFHI: E_hilo = hi;
      OP_MFLO: E_hilo = lo;
      default: E_hilo = '0;
    endcase
  end

  // mul writes LO only, so remember the issued op for the done edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      mul_op <= 1'b0;
    end else begin
      if (mdu_start) begin
        mul_op <= (E_sel_MDU == OP_MUL);
      end
      if (in_run && mdu_done && !req) begin
        lo <= mdu_result[31:0];
        if (!mul_op) begin
          hi <= mdu_result[63:32];
        end
      end
      if ((state == ST_IDLE) && !req) begin
        if (E_sel_MDU == OP_MTHI) hi <= E_rs;
        if (E_sel_MDU == OP_MTLO) lo <= E_rs;
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed self-checking bench for mdu_issue_ctrl; define
// MDU_ISSUE_CTRL_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_mdu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  E_sel_MDU;
  logic [3:0]  D_sel_MDU;
  logic [31:0] E_rs;
  logic        mdu_busy;
  logic        mdu_done;
  logic [63:0] mdu_result;
  logic        mdu_start;
  logic        stall;
  logic [31:0] E_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .E_sel_MDU (E_sel_MDU),
    .D_sel_MDU (D_sel_MDU),
    .E_rs      (E_rs),
    .mdu_busy  (mdu_busy),
    .mdu_done  (mdu_done),
    .mdu_result(mdu_result),
    .mdu_start (mdu_start),
    .stall     (stall),
    .E_hilo    (E_hilo),
    .hi        (hi),
    .lo        (lo),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start op from IDLE; returns with the controller in RUN.
  task automatic issue(input logic [3:0] op);
    E_sel_MDU = op;
    #1;
    check("issue_start", mdu_start, 1'b1);
    step();
    E_sel_MDU = 4'd0;
  endtask

  // IDLE probe: a start op with req=0 must raise mdu_start only in IDLE.
  task automatic check_idle(input string tag, input logic exp_idle);
    logic [3:0] save;
    save = E_sel_MDU;
    E_sel_MDU = 4'd1;
    #1;
    check(tag, mdu_start, exp_idle);
    E_sel_MDU = save;
    #1;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; E_sel_MDU = 4'd0; D_sel_MDU = 4'd0; E_rs = '0;
    mdu_busy = 1'b0; mdu_done = 1'b0; mdu_result = '0;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_err", err, 0);
    check("rst_start", mdu_start, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // mult, done 5 cycles after issue, mflo waiting in decode
    issue(4'd1);
    D_sel_MDU = 4'd6;
    E_sel_MDU = 4'd1;
    #1;
    check("run_no_start", mdu_start, 0);
    E_sel_MDU = 4'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("run_stall", stall, 1);
      step();
    end
    mdu_done = 1'b1; mdu_result = 64'h00000001_FFFFFFFE;
    #1;
    check("done_cyc_stall", stall, 1);
    step();
    mdu_done = 1'b0;
    check("mult_hi", hi, 32'h00000001);
    check("mult_lo", lo, 32'hFFFFFFFE);
    check("post_done_stall", stall, 0);
    E_sel_MDU = 4'd6; D_sel_MDU = 4'd0;
    #1;
    check("mflo_new", E_hilo, 32'hFFFFFFFE);
    E_sel_MDU = 4'd5;
    #1;
    check("mfhi_new", E_hilo, 32'h00000001);
    E_sel_MDU = 4'd3;
    #1;
    check("hilo_other_op", E_hilo, 0);
    E_sel_MDU = 4'd0;
    check_idle("idle_after_done", 1'b1);

    // stray done in IDLE
    mdu_done = 1'b1; mdu_result = 64'hDEADBEEF_DEADBEEF;
    step();
    mdu_done = 1'b0;
    check("idle_done_hi", hi, 32'h00000001);
    check("idle_done_lo", lo, 32'hFFFFFFFE);

    // mul writes lo only
    issue(4'd9);
    step();
    mdu_done = 1'b1; mdu_result = 64'hAAAAAAAA_55555555;
    step();
    mdu_done = 1'b0;
    check("mul_hi_kept", hi, 32'h00000001);
    check("mul_lo", lo, 32'h55555555);

    // req and done together: result discarded
    issue(4'd3);
    req = 1'b1; mdu_done = 1'b1; mdu_result = 64'h11111111_22222222;
    step();
    req = 1'b0; mdu_done = 1'b0;
    check("reqdone_hi", hi, 32'h00000001);
    check("reqdone_lo", lo, 32'h55555555);
    check_idle("reqdone_idle", 1'b1);

    // req alone in RUN aborts; req in IDLE blocks issue
    issue(4'd2);
    step();
    req = 1'b1;
    E_sel_MDU = 4'd1;
    #1;
    check("req_run_start", mdu_start, 0);
    E_sel_MDU = 4'd0;
    step();
    E_sel_MDU = 4'd1;
    #1;
    check("req_idle_start", mdu_start, 0);
    E_sel_MDU = 4'd0;
    req = 1'b0;
    check_idle("req_abort_idle", 1'b1);
    check("req_abort_lo", lo, 32'h55555555);

    // mtlo ignored in RUN, accepted in IDLE
    issue(4'd4);
    E_sel_MDU = 4'd8; E_rs = 32'h12345678;
    step();
    check("mtlo_run_lo", lo, 32'h55555555);
    E_sel_MDU = 4'd0; req = 1'b1;
    step();
    req = 1'b0;
    E_sel_MDU = 4'd8;
    #1;
    check("mflo_pre_edge", lo, 32'h55555555);
    step();
    check("mtlo_idle_lo", lo, 32'h12345678);
    E_sel_MDU = 4'd6;
    #1;
    check("mflo_after_mtlo", E_hilo, 32'h12345678);
    E_sel_MDU = 4'd7; E_rs = 32'hCAFEBABE;
    step();
    check("mthi_idle_hi", hi, 32'hCAFEBABE);
    E_sel_MDU = 4'd0;

    // stall sources in IDLE
    D_sel_MDU = 4'd3; mdu_busy = 1'b1;
    #1;
    check("stall_busy", stall, 1);
    mdu_busy = 1'b0;
    #1;
    check("stall_none", stall, 0);
    E_sel_MDU = 4'd1;
    #1;
    check("stall_on_start", stall, 1);
    E_sel_MDU = 4'd0; D_sel_MDU = 4'd0;

    // reset mid-RUN, then a late done is ignored
    issue(4'd1);
    D_sel_MDU = 4'd6; E_sel_MDU = 4'd1;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_start", mdu_start, 0);
    check("midrst_stall", stall, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0; E_sel_MDU = 4'd0; D_sel_MDU = 4'd0;
    mdu_done = 1'b1; mdu_result = 64'h33333333_44444444;
    step();
    mdu_done = 1'b0;
    check("late_done_lo", lo, 0);
    check("late_done_hi", hi, 0);

`ifdef MDU_ISSUE_CTRL_TIMEOUT_EN
    issue(4'd1);
    D_sel_MDU = 4'd6;
    for (int i = 0; i < 15; i++) step();
    check("to_still_run", stall, 1);
    check("to_err_pre", err, 0);
    step();
    check("to_stall_drop", stall, 0);
    check("to_err", err, 1);
    check("to_lo_kept", lo, 0);
    D_sel_MDU = 4'd0;
    check_idle("to_idle", 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("to_err_sticky", err, 1);
    reset = 1'b1;
    #1;
    check("to_err_reset", err, 0);
    @(negedge clk);
    reset = 1'b0;
`else
    issue(4'd1);
    D_sel_MDU = 4'd6;
    for (int i = 0; i < 40; i++) step();
    check("nto_still_run", stall, 1);
    check("nto_err", err, 0);
    req = 1'b1;
    step();
    req = 1'b0; D_sel_MDU = 4'd0;
    check_idle("nto_idle", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
